// File: rtl/spi_master_cmd_adapter.sv
// spi_master_cmd_adapter: decodes command packets, programs and drives the SPI master, returns one response per command
module spi_master_cmd_adapter #(
  parameter int NBITS = 34,
  parameter int DBITS = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [NBITS-1:0] cmd_msg,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_msg,
  output logic             spi_pkt_size_val,
  input  logic             spi_pkt_size_rdy,
  output logic [DBITS-1:0] spi_pkt_size_msg,
  output logic             spi_cs_addr_val,
  input  logic             spi_cs_addr_rdy,
  output logic [DBITS-1:0] spi_cs_addr_msg,
  output logic             spi_recv_val,
  input  logic             spi_recv_rdy,
  output logic [DBITS-1:0] spi_recv_msg,
  input  logic             spi_send_val,
  output logic             spi_send_rdy,
  input  logic [DBITS-1:0] spi_send_msg,
  output logic             busy
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, CFG_SIZE, CFG_CS, XFER_REQ, XFER_WAIT, RESP} state_t;
  state_t state, state_next;
  logic [NBITS-1:0] resp_reg, resp_next;
  logic [DBITS-1:0] payload;
  logic [5:0] size_shadow;
  logic cs_shadow, dirty;
  logic [CW-1:0] cnt;
  logic [1:0] op;
  logic cmd_hs, send_hs, size_ok, expired;

  assign op = cmd_msg[NBITS-1 -: 2];
  assign cmd_rdy = state == IDLE && reset;
  assign cmd_hs = cmd_val && cmd_rdy;
  assign send_hs = spi_send_val && spi_send_rdy;
  assign size_ok = cmd_msg[5:0] != 6'd0 && cmd_msg[5:0] <= 6'd32;
  assign expired = cnt == CW'(TIMEOUT - 1);
  assign busy = state != IDLE;
  assign resp_val = state == RESP;
  assign resp_msg = resp_reg;
  assign spi_pkt_size_val = state == CFG_SIZE;
  assign spi_pkt_size_msg = DBITS'(size_shadow);
  assign spi_cs_addr_val = state == CFG_CS;
  assign spi_cs_addr_msg = DBITS'(cs_shadow);
  assign spi_recv_val = state == XFER_REQ;
  assign spi_recv_msg = payload;
  assign spi_send_rdy = state == XFER_WAIT;

  // Next state and the response word to hold in RESP
  always_comb begin
    state_next = state;
    resp_next = resp_reg;
    case (state)
      IDLE: if (cmd_hs) begin
        state_next = op == 2'b00 ? (dirty ? CFG_SIZE : XFER_REQ) : RESP;
        resp_next = op == 2'b01 ? {2'b01, size_ok ? {DBITS{1'b0}} : {DBITS{1'b1}}} :
                    op == 2'b10 ? {2'b10, {DBITS{1'b0}}} :
                    op == 2'b11 ? {2'b11, DBITS'({cs_shadow, size_shadow})} : resp_reg;
      end
      CFG_SIZE: state_next = spi_pkt_size_rdy ? CFG_CS : CFG_SIZE;
      CFG_CS: state_next = spi_cs_addr_rdy ? XFER_REQ : CFG_CS;
      XFER_REQ: state_next = spi_recv_rdy ? XFER_WAIT : XFER_REQ;
      XFER_WAIT: begin
        state_next = send_hs || expired ? RESP : XFER_WAIT;
        resp_next = send_hs ? {2'b00, spi_send_msg} :
                    expired ? {2'b11, DBITS'(32'hDEAD_0000)} : resp_reg;
      end
      RESP: state_next = resp_rdy ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  // State and response registers; reset drops every valid immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      resp_reg <= '0;
    end else begin
      state <= state_next;
      resp_reg <= resp_next;
    end
  end

  // Command payload, configuration shadows, dirty flag and saturating wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      payload <= '0;
      size_shadow <= 6'd32;
      cs_shadow <= 1'b0;
      dirty <= 1'b1;
      cnt <= '0;
    end else begin
      if (cmd_hs) payload <= cmd_msg[DBITS-1:0];
      if (cmd_hs && op == 2'b01 && size_ok) size_shadow <= cmd_msg[5:0];
      if (cmd_hs && op == 2'b10) cs_shadow <= cmd_msg[0];
      if (cmd_hs && (op == 2'b10 || (op == 2'b01 && size_ok))) dirty <= 1'b1;
      else if (state == CFG_CS && spi_cs_addr_rdy) dirty <= 1'b0;
      else if (state == XFER_WAIT && expired && !send_hs) dirty <= 1'b1;
      cnt <= state == XFER_WAIT ? (expired ? cnt : cnt + 1'b1) : '0;
    end
  end
endmodule

// File: tb/tb_spi_master_cmd_adapter.sv
// tb_spi_master_cmd_adapter: randomized commands and SPI peer timing checked against a behavioural model
module tb_spi_master_cmd_adapter;
  localparam int TO = 16;
  logic clk = 0, reset = 0;
  logic cmd_val = 0, cmd_rdy, resp_val, resp_rdy = 0;
  logic [33:0] cmd_msg = '0, resp_msg;
  logic spi_pkt_size_val, spi_pkt_size_rdy, spi_cs_addr_val, spi_cs_addr_rdy;
  logic spi_recv_val, spi_recv_rdy, spi_send_val, spi_send_rdy, busy;
  logic [31:0] spi_pkt_size_msg, spi_cs_addr_msg, spi_recv_msg, spi_send_msg;
  int errors = 0, checks = 0;
  logic [31:0] size_q[$], cs_q[$], recv_q[$];
  int wait_cnt = 0;
  bit hang = 0, hold_recv = 0;
  logic [31:0] miso = '0;
  int m_size = 32, m_cs = 0;
  bit m_dirty = 1;

  spi_master_cmd_adapter #(.NBITS(34), .DBITS(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_msg(cmd_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .spi_pkt_size_val(spi_pkt_size_val), .spi_pkt_size_rdy(spi_pkt_size_rdy), .spi_pkt_size_msg(spi_pkt_size_msg),
    .spi_cs_addr_val(spi_cs_addr_val), .spi_cs_addr_rdy(spi_cs_addr_rdy), .spi_cs_addr_msg(spi_cs_addr_msg),
    .spi_recv_val(spi_recv_val), .spi_recv_rdy(spi_recv_rdy), .spi_recv_msg(spi_recv_msg),
    .spi_send_val(spi_send_val), .spi_send_rdy(spi_send_rdy), .spi_send_msg(spi_send_msg),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // SPI master peer: random readies, records accepted writes, echoes MISO after a random delay
  initial begin
    int dly = -1;
    bit rhs, shs;
    spi_pkt_size_rdy = 0; spi_cs_addr_rdy = 0; spi_recv_rdy = 0;
    spi_send_val = 0; spi_send_msg = '0;
    forever begin
      @(negedge clk);
      rhs = spi_recv_val && spi_recv_rdy;
      shs = spi_send_val && spi_send_rdy;
      if (spi_pkt_size_val && spi_pkt_size_rdy) size_q.push_back(spi_pkt_size_msg);
      if (spi_cs_addr_val && spi_cs_addr_rdy) cs_q.push_back(spi_cs_addr_msg);
      if (rhs) recv_q.push_back(spi_recv_msg);
      if (spi_send_rdy) wait_cnt++;
      @(posedge clk);
      #1;
      if (shs || !reset) spi_send_val = 0;
      if (!reset) dly = -1;
      else if (rhs && !hang) dly = $urandom_range(0, 3);
      if (dly == 0) begin
        spi_send_val = 1;
        spi_send_msg = miso;
      end
      if (dly >= 0) dly--;
      spi_pkt_size_rdy = 1'($urandom_range(0, 1));
      spi_cs_addr_rdy = 1'($urandom_range(0, 1));
      spi_recv_rdy = hold_recv ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] pl, input logic [31:0] mw, input bit hg, input int stall);
    logic [33:0] want;
    logic [31:0] esz[$], ecs[$], erv[$];
    int lat, n;
    want = '0;
    case (op)
      2'b00: begin
        if (m_dirty) begin
          esz.push_back(32'(m_size));
          ecs.push_back(32'(m_cs));
        end
        erv.push_back(pl);
        want = hg ? {2'b11, 32'hDEAD_0000} : {2'b00, mw};
        m_dirty = hg;
      end
      2'b01: begin
        n = int'(pl % 64);
        if (n >= 1 && n <= 32) begin
          m_size = n;
          m_dirty = 1;
          want = {2'b01, 32'h0};
        end else want = {2'b01, 32'hFFFF_FFFF};
      end
      2'b10: begin
        m_cs = int'(pl % 2);
        m_dirty = 1;
        want = {2'b10, 32'h0};
      end
      default: want = {2'b11, 32'(m_cs * 64 + m_size)};
    endcase
    size_q.delete(); cs_q.delete(); recv_q.delete();
    wait_cnt = 0; hang = hg; miso = mw;
    @(posedge clk);
    #1;
    cmd_val = 1;
    cmd_msg = {op, pl};
    n = 0;
    do @(negedge clk); while (!cmd_rdy && ++n < 50);
    check("cmd_rdy", cmd_rdy, 1);
    @(posedge clk);
    #1;
    cmd_val = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_val && lat < 200);
    check("resp_val", resp_val, 1);
    check("resp_msg", resp_msg, want);
    if (op != 2'b00) check("cfg_latency", lat, 1);
    repeat (stall) begin
      @(negedge clk);
      check("bp_val", resp_val, 1);
      check("bp_msg", resp_msg, want);
      check("bp_cmd_rdy", cmd_rdy, 0);
    end
    @(posedge clk);
    #1;
    resp_rdy = 1;
    @(posedge clk);
    #1;
    resp_rdy = 0;
    check("n_size", size_q.size(), esz.size());
    check("n_cs", cs_q.size(), ecs.size());
    check("n_recv", recv_q.size(), erv.size());
    foreach (esz[i]) if (i < size_q.size()) check("size_msg", size_q[i], esz[i]);
    foreach (ecs[i]) if (i < cs_q.size()) check("cs_msg", cs_q[i], ecs[i]);
    foreach (erv[i]) if (i < recv_q.size()) check("recv_msg", recv_q[i], erv[i]);
    if (op == 2'b00 && hg) check("wait_cycles", wait_cnt, TO);
  endtask

  initial begin
    logic [1:0] op;
    logic [31:0] pl;
    repeat (3) @(negedge clk);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_msg", resp_msg, 0);
    check("rst_vals", {resp_val, spi_pkt_size_val, spi_cs_addr_val, spi_recv_val, spi_send_rdy}, 0);
    reset = 1;
    @(negedge clk);
    check("idle_cmd_rdy", cmd_rdy, 1);
    check("idle_send_rdy", spi_send_rdy, 0);
    run_cmd(2'b00, 32'h0000_00A5, 32'h1234_5678, 0, 0);
    run_cmd(2'b01, 32'd8, 0, 0, 0);
    run_cmd(2'b10, 32'd1, 0, 0, 0);
    run_cmd(2'b11, 0, 0, 0, 0);
    run_cmd(2'b00, 32'h0F0F_0F0F, 32'hA5A5_5A5A, 0, 0);
    run_cmd(2'b00, 32'h7777_0001, 32'h0000_FFFF, 0, 0);
    run_cmd(2'b01, 32'd32, 0, 0, 0);
    run_cmd(2'b01, 32'd0, 0, 0, 0);
    run_cmd(2'b01, 32'd33, 0, 0, 0);
    run_cmd(2'b11, 0, 0, 0, 0);
    run_cmd(2'b00, 32'h0000_0042, 0, 1, 0);
    run_cmd(2'b00, 32'h0000_0043, 32'h8765_4321, 0, 0);
    run_cmd(2'b10, 32'd0, 0, 0, 5);
    hold_recv = 1;
    fork
      run_cmd(2'b00, 32'hCAFE_0001, 32'h0BAD_F00D, 0, 0);
      begin
        for (int n = 0; n < 100 && !spi_recv_val; n++) @(negedge clk);
        check("recv_val_up", spi_recv_val, 1);
        repeat (3) begin
          @(negedge clk);
          check("recv_hold_val", spi_recv_val, 1);
          check("recv_hold_msg", spi_recv_msg, 32'hCAFE_0001);
        end
        hold_recv = 0;
      end
    join
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      pl = $urandom;
      if (op == 2'b01) pl = (pl & ~32'h3F) | 32'($urandom_range(0, 63));
      run_cmd(op, pl, $urandom, op == 2'b00 && $urandom_range(0, 5) == 0, $urandom_range(0, 2));
    end
    hang = 1;
    @(posedge clk);
    #1;
    cmd_val = 1;
    cmd_msg = {2'b00, 32'h5555_AAAA};
    for (int n = 0; n < 50 && !cmd_rdy; n++) @(negedge clk);
    @(posedge clk);
    #1;
    cmd_val = 0;
    for (int n = 0; n < 100 && !spi_send_rdy; n++) @(negedge clk);
    check("reach_wait", spi_send_rdy, 1);
    #2;
    reset = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_vals", {resp_val, spi_pkt_size_val, spi_cs_addr_val, spi_recv_val, spi_send_rdy, cmd_rdy}, 0);
    repeat (3) begin
      @(negedge clk);
      check("arst_no_resp", resp_val, 0);
    end
    reset = 1;
    hang = 0;
    m_size = 32; m_cs = 0; m_dirty = 1;
    repeat (2) @(negedge clk);
    check("post_rst_resp", resp_val, 0);
    run_cmd(2'b11, 0, 0, 0, 0);
    run_cmd(2'b00, 32'h0000_1111, 32'h2222_3333, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule
